led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Drives the enable and rate-select inputs of one led_blinker through a fixed table of
//  blink steps. Each step is a rate code plus a dwell time, with an optional dark gap
//  between steps. Sits between board-level control (start/abort) and the blinker;
//  it replaces static switch wiring with a timed blink pattern.
// PARAMETERS
//  NUM_STEPS  4        number of table entries (1..16)
//  DWELL_W    8        width of per-step dwell field, in ticks
//  TICK_DIV   1000     i_clock cycles per dwell/gap tick (>=1)
//  GAP_TICKS  1        dark ticks between consecutive steps; 0 = no gap
//  PATTERN    {..}     packed table, NUM_STEPS*(2+DWELL_W) bits; entry k at [k*(2+DWELL_W) +: 2+DWELL_W]
//                      entry bits [DWELL_W+1:DWELL_W] = rate code, [DWELL_W-1:0] = dwell ticks
// PORTS
//  i_clock     in   1        system clock
//  i_reset     in   1        asynchronous, active-high reset
//  i_start     in   1        start pulse; sampled only in IDLE
//  i_abort     in   1        abort; forces IDLE from any state
//  o_enable    out  1        to blinker i_enable
//  o_switch_1  out  1        to blinker i_switch_1 (rate code bit 1)
//  o_switch_2  out  1        to blinker i_switch_2 (rate code bit 0)
//  o_busy      out  1        high in any state except IDLE
//  o_done      out  1        one-cycle pulse at sequence completion
//  o_step      out  STEP_W   current table index, STEP_W = $clog2(NUM_STEPS) (min 1)
// BEHAVIOUR
//  - Rate codes {sw1,sw2}: 00=100Hz, 01=50Hz, 10=10Hz, 11=1Hz.
//  - All outputs are registered. While i_reset is high, all outputs are 0 and state is IDLE.
//  - FSM: IDLE -> LOAD -> RUN -> GAP -> LOAD ... -> IDLE.
//  - IDLE: i_start=1 at edge N -> LOAD at N+1 with o_step=0. o_busy rises at N+1.
//  - LOAD (1 cycle, o_enable=0): latch the entry's rate onto the switches.
//    If dwell==0, the step is skipped and goes straight to the next LOAD (no gap).
//    Otherwise the state goes to RUN.
//  - RUN: o_enable=1 for exactly dwell*TICK_DIV cycles; switches are held stable.
//  - GAP: o_enable=0 for GAP_TICKS*TICK_DIV cycles, then LOAD of step+1.
//    GAP_TICKS=0 goes from RUN directly to LOAD.
//  - There is no gap after the last step.
//  - After the last step, o_done pulses 1 cycle, o_busy falls and the switches
//    return to 00, all in the same cycle the FSM enters IDLE.
//  - Counter widths: the tick prescaler is $clog2(TICK_DIV) bits. It clears on every
//    state entry, so durations are exact with no carry-over between states.
//    The dwell/gap counter is max(DWELL_W, width of GAP_TICKS) bits and counts down.
//  - i_abort=1: next edge -> IDLE, o_enable=0, switches=00, o_step=0, and no o_done.
//    Abort takes priority over i_start in the same cycle.
//  - i_start while busy is ignored (no restart, no queueing).
//  - Reset mid-operation clears everything asynchronously. No o_done is produced.
// CONFIGURATION
//  LED_SEQ_LOOP_EN defined:
//    - After the last step, the sequencer goes to GAP and then to LOAD of step 0,
//      instead of IDLE.
//    - o_done pulses once per wrap; o_busy stays high.
//    - Only i_abort or i_reset stops the sequence.
//  LED_SEQ_LOOP_EN undefined: single-shot behaviour as above.
// STRUCTURE
//  - Package led_pkg:
//    - localparams RATE_100HZ=2'b00, RATE_50HZ=2'b01, RATE_10HZ=2'b10, RATE_1HZ=2'b11;
//    - state encoding ST_IDLE, ST_LOAD, ST_RUN, ST_GAP.
//  - Sub-module led_seq_dwell_timer:
//    - TICK_DIV prescaler plus loadable down-counter;
//    - inputs clear/load value, output expired.
//    - The FSM, table indexing and output registers stay in the top module.
// TESTING (bench: TICK_DIV=4, NUM_STEPS=3, GAP_TICKS=1, entries {rate,dwell} = {00,2},{10,0},{11,3})
//  1. Reset asserted -> all outputs 0, o_step=0; hold 5 cycles after release -> still idle.
//  2. Pulse i_start -> o_enable=1 two cycles later for 8 cycles at switches=00;
//     then 4 dark cycles; step1 is skipped; then 12 cycles at switches=11;
//     then one o_done pulse and o_busy falls.
//  3. i_abort during step2 RUN -> o_enable and switches are 0 on the next cycle,
//     o_busy falls, no o_done pulse.
//  4. i_start pulsed mid-RUN -> timing is unchanged.
//     i_start and i_abort together in IDLE -> stays IDLE.
//  5. i_reset asserted between clock edges during RUN -> outputs go 0 without waiting
//     for an edge. A fresh i_start after release replays from step 0.
//  6. With LED_SEQ_LOOP_EN -> after step2 there is a 4-cycle gap, then step0 again.
//     o_done pulses once per wrap for 3 wraps, and o_busy stays high until i_abort.

Source files
------------

// File: rtl/led_pkg.sv
// Shared rate codes and sequencer state encoding for the LED pattern sequencer.
package led_pkg;

  localparam logic [1:0] RATE_100HZ = 2'b00;
  localparam logic [1:0] RATE_50HZ  = 2'b01;
  localparam logic [1:0] RATE_10HZ  = 2'b10;
  localparam logic [1:0] RATE_1HZ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/led_seq_dwell_timer.sv
// Tick prescaler plus loadable down-counter; o_expired marks the final cycle of a
// loaded interval of i_load_val*TICK_DIV cycles.
module led_seq_dwell_timer #(
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_MAX);

  // Prescaler restarts from zero on every load so each interval is exact.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_pre <= '0;
      r_cnt <= i_load_val;
    end else if (i_clear) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      if (w_tick) begin
        r_pre <= '0;
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign o_expired = w_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps an led_blinker through a table of {rate, dwell} entries with optional dark gaps.
// Define LED_SEQ_LOOP_EN to repeat the table until abort instead of running once.
module led_pattern_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int DWELL_W   = 8,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1,
  parameter logic [NUM_STEPS*(2+DWELL_W)-1:0] PATTERN =
    {2'b11, 8'd10, 2'b10, 8'd10, 2'b01, 8'd10, 2'b00, 8'd10},
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_enable,
  output logic              o_switch_1,
  output logic              o_switch_2,
  output logic              o_busy,
  output logic              o_done,
  output logic [STEP_W-1:0] o_step
);

  import led_pkg::*;

  localparam int ENTRY_W = 2 + DWELL_W;
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W   = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;
  localparam bit HAS_GAP = (GAP_TICKS != 0);
`ifdef LED_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  seq_state_t        r_state;
  logic [STEP_W-1:0] r_step;
  logic              r_enable;
  logic [1:0]        r_rate;
  logic              r_busy;
  logic              r_done;

  seq_state_t        w_next_state;
  logic [STEP_W-1:0] w_next_step;
  logic [STEP_W-1:0] w_step_inc;
  logic [DWELL_W-1:0] w_cur_dwell;
  logic [1:0]        w_next_rate;
  logic              w_last;
  logic              w_done;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_clear;
  logic              w_expired;

  assign w_cur_dwell = PATTERN[int'(r_step)*ENTRY_W +: DWELL_W];
  assign w_next_rate = PATTERN[int'(w_next_step)*ENTRY_W + DWELL_W +: 2];
  assign w_last      = (r_step == STEP_W'(NUM_STEPS - 1));
  assign w_step_inc  = r_step + STEP_W'(1);
  assign w_clear     = (w_next_state == ST_LOAD) || (w_next_state == ST_IDLE);

  led_seq_dwell_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_done       = 1'b0;
    w_load       = 1'b0;
    w_load_val   = CNT_W'(w_cur_dwell);
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_LOAD;
          w_next_step  = '0;
        end
      end
      ST_LOAD: begin
        // A zero-dwell entry is skipped without a gap.
        if (w_cur_dwell == '0) begin
          w_next_state = ST_LOAD;
          w_next_step  = w_step_inc;
          if (w_last) begin
            w_done      = 1'b1;
            w_next_step = '0;
            if (!LOOP_EN) w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_RUN;
          w_load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_expired) begin
          if (w_last) w_done = 1'b1;
          if (w_last && !LOOP_EN) begin
            w_next_state = ST_IDLE;
            w_next_step  = '0;
          end else if (HAS_GAP) begin
            w_next_state = ST_GAP;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(GAP_TICKS);
          end else begin
            w_next_state = ST_LOAD;
            w_next_step  = w_last ? '0 : w_step_inc;
          end
        end
      end
      ST_GAP: begin
        if (w_expired) begin
          w_next_state = ST_LOAD;
          w_next_step  = w_last ? '0 : w_step_inc;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_step  = '0;
      end
    endcase
    if (i_abort) begin
      w_next_state = ST_IDLE;
      w_next_step  = '0;
      w_done       = 1'b0;
      w_load       = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_step   <= '0;
      r_enable <= 1'b0;
      r_rate   <= RATE_100HZ;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_step   <= w_next_step;
      r_enable <= (w_next_state == ST_RUN);
      r_busy   <= (w_next_state != ST_IDLE);
      r_done   <= w_done;
      if (w_next_state == ST_IDLE)      r_rate <= RATE_100HZ;
      else if (w_next_state == ST_LOAD) r_rate <= w_next_rate;
    end
  end

  assign o_enable   = r_enable;
  assign o_switch_1 = r_rate[1];
  assign o_switch_2 = r_rate[0];
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_step     = r_step;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: per-cycle comparison against a timeline model of the table.
module tb_led_pattern_sequencer;

  localparam int TD    = 4;
  localparam int NSTEP = 3;
  localparam int GAPT  = 1;
  localparam int LAST  = NSTEP - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       o_enable, o_switch_1, o_switch_2, o_busy, o_done;
  logic [1:0] o_step;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .NUM_STEPS (NSTEP),
    .DWELL_W   (8),
    .TICK_DIV  (TD),
    .GAP_TICKS (GAPT),
    .PATTERN   ({2'b11, 8'd3, 2'b10, 8'd0, 2'b00, 8'd2})
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_abort    (abort),
    .o_enable   (o_enable),
    .o_switch_1 (o_switch_1),
    .o_switch_2 (o_switch_2),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_step     (o_step)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] sw;
    logic       busy;
    logic       done;
    logic [1:0] step;
  } obs_t;

  int   rate_tab [NSTEP] = '{0, 2, 3};
  int   dwell_tab[NSTEP] = '{2, 0, 3};
  obs_t q[$];
  bit   looping = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t mk(input logic en, input int sw, input logic busy,
                              input logic done, input int step);
    obs_t o;
    o.en   = en;
    o.sw   = sw[1:0];
    o.busy = busy;
    o.done = done;
    o.step = step[1:0];
    return o;
  endfunction

  // One pass over the table as a cycle-by-cycle list of expected outputs.
  task automatic push_pass(input bit wrap);
    for (int k = 0; k < NSTEP; k++) begin
      q.push_back(mk(1'b0, rate_tab[k], 1'b1, 1'b0, k));
      if (dwell_tab[k] != 0) begin
        for (int c = 0; c < dwell_tab[k]*TD; c++)
          q.push_back(mk(1'b1, rate_tab[k], 1'b1, 1'b0, k));
        if (k != LAST || wrap)
          for (int c = 0; c < GAPT*TD; c++)
            q.push_back(mk(1'b0, rate_tab[k], 1'b1, (wrap && k == LAST && c == 0), k));
      end
    end
    if (!wrap) q.push_back(mk(1'b0, 0, 1'b0, 1'b1, 0));
  endtask

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o.en   = o_enable;
    o.sw   = {o_switch_1, o_switch_2};
    o.busy = o_busy;
    o.done = o_done;
    o.step = o_step;
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed en/sw/busy/done/step=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
             tag, o.en, o.sw, o.busy, o.done, o.step, e.en, e.sw, e.busy, e.done, e.step);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  task automatic tick(input string tag);
    obs_t e;
    if (rst || abort) begin
      q.delete();
      looping = 1'b0;
    end else if (q.size() == 0 && looping) begin
      push_pass(1'b1);
    end else if (q.size() == 0 && start) begin
`ifdef LED_SEQ_LOOP_EN
      looping = 1'b1;
      push_pass(1'b1);
`else
      push_pass(1'b0);
`endif
    end
    e = (q.size() > 0) ? q.pop_front() : obs_t'(0);
    @(posedge clk);
    #1;
    check(tag, e);
  endtask

  task automatic run_until_idle(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      tick(tag);
      guard++;
    end
    check_int({tag, "_bound"}, guard < 200, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, done_cnt, busy_low, n, ab_at;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #3;
    check("reset_async", obs_t'(0));
    tick("reset_held");
    tick("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick("idle_after_reset");

`ifndef LED_SEQ_LOOP_EN
    start = 1'b1;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 28; i++) begin
      tick("seq_basic");
      start = 1'b0;
      en_cnt += int'(o_enable);
      done_cnt += int'(o_done);
    end
    check_int("enable_cycles", en_cnt, 20);
    check_int("done_pulses", done_cnt, 1);
    tick("idle_after_done");

    start = 1'b1;
    tick("abort_run_start");
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick("abort_run_pre");
    check_int("in_step2_run", int'(o_enable & (o_step == 2'd2)), 1);
    abort = 1'b1;
    tick("abort_run");
    abort = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick("abort_run_after");
      done_cnt += int'(o_done);
    end
    check_int("abort_no_done", done_cnt, 0);

    start = 1'b1;
    tick("start_busy_begin");
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick("start_busy_pre");
    start = 1'b1;
    tick("start_busy");
    start = 1'b0;
    run_until_idle("start_busy_post");
    start = 1'b1; abort = 1'b1;
    tick("start_abort_idle");
    start = 1'b0; abort = 1'b0;
    tick("start_abort_after");
    check_int("start_abort_busy", int'(o_busy), 0);

    start = 1'b1;
    tick("reset_run_begin");
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick("reset_run_pre");
    #2 rst = 1'b1;
    #1 check("reset_mid_run", obs_t'(0));
    tick("reset_mid_held");
    rst = 1'b0;
    tick("reset_mid_idle");
    start = 1'b1;
    tick("replay_begin");
    start = 1'b0;
    run_until_idle("replay");
`else
    start = 1'b1;
    done_cnt = 0; busy_low = 0;
    for (int i = 0; i < 93; i++) begin
      tick("loop_run");
      start = 1'b0;
      done_cnt += int'(o_done);
      busy_low += int'(!o_busy);
    end
    check_int("loop_done_pulses", done_cnt, 3);
    check_int("loop_busy_low", busy_low, 0);
    abort = 1'b1;
    tick("loop_abort");
    abort = 1'b0;
    tick("loop_after_abort");
`endif

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        abort = ($urandom_range(0, 1) == 0);
        tick("rand_idle");
      end
      abort = 1'b0;
      start = 1'b1;
      tick("rand_start");
      start = 1'b0;
      n = $urandom_range(3, 40);
      ab_at = (it % 2 == 1) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) begin
        start = ($urandom_range(0, 3) == 0);
        abort = (i == ab_at);
        tick("rand_run");
      end
      start = 1'b0;
      abort = 1'b1;
      tick("rand_abort");
      abort = 1'b0;
      tick("rand_settle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
